// File: rtl/load_store_unit_if.sv
// load_store_unit_if: req/ready data-memory bus between the load/store unit and memory
//   master (load/store unit) drives: bus_req, bus_we, bus_addr, bus_be, bus_wdata
//   slave  (data memory)     drives: bus_ready, bus_rdata
interface load_store_unit_if #(parameter int ADDR_W = 32);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [3:0]        bus_be;
   logic [31:0]       bus_wdata;
   logic              bus_ready;
   logic [31:0]       bus_rdata;
   modport master(output bus_req, bus_we, bus_addr, bus_be, bus_wdata, input bus_ready, bus_rdata);
   modport slave(input bus_req, bus_we, bus_addr, bus_be, bus_wdata, output bus_ready, bus_rdata);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: handshaked load/store unit between the RISC-V datapath and data memory
//   clk, rst            core clock, synchronous active-high reset
//   mem_read/mem_write  current instruction is a load/store
//   func3, addr, wdata  access size/sign, byte address, store data
//   stall               hold PC and register write this cycle
//   rdata               extended load data, valid in DONE
//   access_fault        one-cycle pulse after a misaligned or illegal access
//   bus                 req/ready memory bus (master side)
module load_store_unit #(parameter int ADDR_W = 32) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        func3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              access_fault,
   load_store_unit_if.master bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state, state_n;
   logic req, legal, issue, fault;
   logic [1:0] off;
   logic [2:0] f3;
   logic [7:0] byte_v;
   logic [15:0] half_v;
   logic [31:0] ext;
   assign bus.bus_req = state == ACCESS;
   always_comb begin
      req = mem_read | mem_write;
      legal = !(mem_read & mem_write)
            & (mem_write ? func3 inside {3'd0, 3'd1, 3'd2} : func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
            & !(func3[1:0] == 2'b01 & addr[0])
            & !(func3[1:0] == 2'b10 & addr[1:0] != 2'b00);
      issue = state == IDLE & req & legal;
      fault = state == IDLE & req & !legal;
      stall = !rst & (issue | state == ACCESS);
      state_n = state == IDLE ? (issue ? ACCESS : IDLE)
              : state == ACCESS ? (bus.bus_ready ? DONE : ACCESS)
              : IDLE;
      // lane extraction uses the offset and func3 latched at issue, not the live inputs
      byte_v = bus.bus_rdata[{off, 3'b000} +: 8];
      half_v = bus.bus_rdata[{off[1], 4'b0000} +: 16];
      ext = f3[1:0] == 2'b00 ? {{24{~f3[2] & byte_v[7]}}, byte_v}
          : f3[1:0] == 2'b01 ? {{16{~f3[2] & half_v[15]}}, half_v}
          : bus.bus_rdata;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bus.bus_we <= 1'b0;
         bus.bus_addr <= '0;
         bus.bus_be <= 4'b0000;
         bus.bus_wdata <= 32'd0;
         rdata <= 32'd0;
         access_fault <= 1'b0;
         off <= 2'b00;
         f3 <= 3'b000;
      end else begin
         state <= state_n;
         access_fault <= fault;
         if (fault) rdata <= 32'd0;
         if (issue) begin
            bus.bus_we <= mem_write;
            bus.bus_addr <= {addr[ADDR_W-1:2], 2'b00};
            bus.bus_be <= !mem_write ? 4'b0000
                        : func3[1:0] == 2'b00 ? 4'b0001 << addr[1:0]
                        : func3[1:0] == 2'b01 ? 4'b0011 << addr[1:0]
                        : 4'b1111;
            bus.bus_wdata <= func3[1:0] == 2'b00 ? {4{wdata[7:0]}}
                           : func3[1:0] == 2'b01 ? {2{wdata[15:0]}}
                           : wdata;
            off <= addr[1:0];
            f3 <= func3;
         end
         if (state == ACCESS & bus.bus_ready & !bus.bus_we) rdata <= ext;
      end
   end
endmodule
